pattern_detect_fsm: RTL and testbench

PATTERN_DETECT_FSM -- requirements
Module: pattern_detect_fsm

---
 rtl/pattern_detect_fsm.sv | 88 ++++++++
 tb/tb_pattern_detect_fsm.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pattern_detect_fsm.sv
// Serial pattern detector with a saturating match counter.
// The detector tracks the last PAT_W-1 accepted bits plus a fill level;
// a match is flagged combinationally on the accepted bit that completes PATTERN.
module pattern_detect_fsm #(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             data_in,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  // Fill level width: must hold 0..PAT_W-1.
  localparam int FW = (PAT_W <= 2) ? 1 : $clog2(PAT_W);

  // Fill levels act as the detector's states; only the endpoints need names.
  localparam logic [FW-1:0] FILL_EMPTY = '0;
  localparam logic [FW-1:0] FILL_FULL  = FW'(PAT_W - 1);

  logic [PAT_W-2:0] hist_q, hist_d, hist_shift;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  // History shift: a 2-bit pattern keeps just one bit of history.
  generate
    if (PAT_W == 2) begin : g_hist_one
      assign hist_shift = data_in;
    end else begin : g_hist_many
      assign hist_shift = {hist_q[PAT_W-3:0], data_in};
    end
  endgenerate

  // Match needs a full history window; reset and clear both suppress it.
  assign match = rstn & en & ~clr & (fill_q == FILL_FULL) &
                 ({hist_q, data_in} == PATTERN);

  assign match_count = cnt_q;
  assign count_sat   = sat_q;

  // Next-state: clear beats accept; idle cycles hold everything.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    if (clr) begin
      fill_d = FILL_EMPTY;
      cnt_d  = '0;
      sat_d  = 1'b0;
    end else if (en) begin
      hist_d = hist_shift;
      if (match && (OVERLAP == 0)) begin
        // Non-overlapping: the matched bits are consumed, start over.
        fill_d = FILL_EMPTY;
      end else if (fill_q != FILL_FULL) begin
        fill_d = fill_q + 1'b1;
      end
      if (match && !sat_q) begin
        cnt_d = cnt_q + 1'b1;
        sat_d = &cnt_d;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hist_q <= '0;
      fill_q <= FILL_EMPTY;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

endmodule

// File: tb/tb_pattern_detect_fsm.sv
// Directed bench: three detector instances (overlapping, non-overlapping,
// 2-bit saturating counter) share one stimulus stream.
module tb_pattern_detect_fsm;

  logic clk = 1'b0;
  logic rstn, en, data_in, clr;

  logic       match_ov, match_nov, match_sat;
  logic [7:0] cnt_ov, cnt_nov;
  logic [1:0] cnt_sat;
  logic       sat_ov, sat_nov, sat_sat;

  logic m_ov, m_nov, m_sat;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pattern_detect_fsm #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1), .CNT_W(8)) dut_ov (
    .clk(clk), .rstn(rstn), .en(en), .data_in(data_in), .clr(clr),
    .match(match_ov), .match_count(cnt_ov), .count_sat(sat_ov));

  pattern_detect_fsm #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(0), .CNT_W(8)) dut_nov (
    .clk(clk), .rstn(rstn), .en(en), .data_in(data_in), .clr(clr),
    .match(match_nov), .match_count(cnt_nov), .count_sat(sat_nov));

  pattern_detect_fsm #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rstn(rstn), .en(en), .data_in(data_in), .clr(clr),
    .match(match_sat), .match_count(cnt_sat), .count_sat(sat_sat));

  // Drive one cycle: inputs set after negedge, match sampled before posedge,
  // registered outputs settle 1 time unit after posedge.
  task automatic step(input logic e, input logic d, input logic c);
    @(negedge clk);
    en = e; data_in = d; clr = c;
    #1;
    m_ov = match_ov; m_nov = match_nov; m_sat = match_sat;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    total++;
    if (m_ov !== 1'b0) begin bad++; $display("FAIL reset_match got=%b exp=0", m_ov); end
    total++;
    if (cnt_ov !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt_ov); end
    total++;
    if (sat_ov !== 1'b0 || sat_sat !== 1'b0) begin
      bad++; $display("FAIL reset_sat got=%b/%b exp=0/0", sat_ov, sat_sat);
    end
    total++;
    if (dut_ov.fill_q !== 2'd0) begin bad++; $display("FAIL reset_fill got=%0d exp=0", dut_ov.fill_q); end
    rstn = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_overlap_stream();
    logic [4:0] bits   = 5'b10101;
    logic [4:0] exp_ov = 5'b00101;
    logic [4:0] exp_nv = 5'b00100;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, bits[4-i], 1'b0);
      total++;
      if (m_ov !== exp_ov[4-i]) begin
        bad++; $display("FAIL ov_match bit%0d got=%b exp=%b", i+1, m_ov, exp_ov[4-i]);
      end
      total++;
      if (m_nov !== exp_nv[4-i]) begin
        bad++; $display("FAIL nov_match bit%0d got=%b exp=%b", i+1, m_nov, exp_nv[4-i]);
      end
      $display("stream bit%0d d=%b match ov=%b nov=%b", i+1, bits[4-i], m_ov, m_nov);
    end
    total++;
    if (cnt_ov !== 8'd2) begin bad++; $display("FAIL ov_count got=%0d exp=2", cnt_ov); end
    total++;
    if (cnt_nov !== 8'd1) begin bad++; $display("FAIL nov_count got=%0d exp=1", cnt_nov); end
    total++;
    if (dut_nov.fill_q !== 2'd2) begin bad++; $display("FAIL nov_fill got=%0d exp=2", dut_nov.fill_q); end
    total++;
    if (cnt_sat !== 2'd2 || sat_sat !== 1'b0) begin
      bad++; $display("FAIL sat_mid got=%0d/%b exp=2/0", cnt_sat, sat_sat);
    end
  endtask

  task automatic test_en_gap();
    step(1'b0, 1'b0, 1'b1);
    total++;
    if (cnt_ov !== 8'd0) begin bad++; $display("FAIL gap_clr got=%0d exp=0", cnt_ov); end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, (i == 3) ? 1'bx : i[0], 1'b0);
      total++;
      if (m_ov !== 1'b0) begin bad++; $display("FAIL gap_idle_match cyc%0d got=%b exp=0", i, m_ov); end
      $display("gap idle cycle %0d match=%b", i, m_ov);
    end
    total++;
    if (cnt_ov !== 8'd0) begin bad++; $display("FAIL gap_idle_cnt got=%0d exp=0", cnt_ov); end
    step(1'b1, 1'b1, 1'b0);
    total++;
    if (m_ov !== 1'b1) begin bad++; $display("FAIL gap_match got=%b exp=1", m_ov); end
    total++;
    if (cnt_ov !== 8'd1) begin bad++; $display("FAIL gap_count got=%0d exp=1", cnt_ov); end
    $display("gap final match=%b count=%0d", m_ov, cnt_ov);
  endtask

  task automatic test_saturate();
    int exp_cnt[11] = '{0,0,1,1,2,2,3,3,3,3,3};
    int exp_sat[11] = '{0,0,0,0,0,0,1,1,1,1,1};
    logic exp_m;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      exp_m = (i >= 2) && (i % 2 == 0);
      step(1'b1, ~i[0], 1'b0);
      total++;
      if (m_sat !== exp_m) begin bad++; $display("FAIL sat_match bit%0d got=%b exp=%b", i+1, m_sat, exp_m); end
      total++;
      if (cnt_sat !== 2'(exp_cnt[i])) begin
        bad++; $display("FAIL sat_count bit%0d got=%0d exp=%0d", i+1, cnt_sat, exp_cnt[i]);
      end
      total++;
      if (sat_sat !== 1'(exp_sat[i])) begin
        bad++; $display("FAIL sat_flag bit%0d got=%b exp=%0d", i+1, sat_sat, exp_sat[i]);
      end
      $display("sat bit%0d match=%b count=%0d sat=%b", i+1, m_sat, cnt_sat, sat_sat);
    end
    total++;
    if (cnt_ov !== 8'd5 || sat_ov !== 1'b0) begin
      bad++; $display("FAIL sat_wide got=%0d/%b exp=5/0", cnt_ov, sat_ov);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    rstn = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    total++;
    if (m_ov !== 1'b0) begin bad++; $display("FAIL rstmid_hold_match got=%b exp=0", m_ov); end
    rstn = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    total++;
    if (m_ov !== 1'b0) begin bad++; $display("FAIL rstmid_first got=%b exp=0", m_ov); end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    total++;
    if (m_ov !== 1'b1) begin bad++; $display("FAIL rstmid_match got=%b exp=1", m_ov); end
    total++;
    if (cnt_ov !== 8'd1) begin bad++; $display("FAIL rstmid_count got=%0d exp=1", cnt_ov); end
    $display("reset-mid final match=%b count=%0d", m_ov, cnt_ov);
  endtask

  task automatic test_clr_priority();
    logic [5:0] bits = 6'b101010;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, bits[5-i], 1'b0);
    total++;
    if (cnt_ov !== 8'd2) begin bad++; $display("FAIL clr_pre_count got=%0d exp=2", cnt_ov); end
    // History is now 1,0 with a full window: data 1 would match without clr.
    step(1'b1, 1'b1, 1'b1);
    total++;
    if (m_ov !== 1'b0) begin bad++; $display("FAIL clr_match got=%b exp=0", m_ov); end
    total++;
    if (cnt_ov !== 8'd0 || sat_ov !== 1'b0) begin
      bad++; $display("FAIL clr_count got=%0d/%b exp=0/0", cnt_ov, sat_ov);
    end
    total++;
    if (dut_ov.fill_q !== 2'd0) begin bad++; $display("FAIL clr_fill got=%0d exp=0", dut_ov.fill_q); end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    total++;
    if (m_ov !== 1'b0) begin bad++; $display("FAIL clr_early got=%b exp=0", m_ov); end
    step(1'b1, 1'b1, 1'b0);
    total++;
    if (m_ov !== 1'b1) begin bad++; $display("FAIL clr_after_match got=%b exp=1", m_ov); end
    total++;
    if (cnt_ov !== 8'd1) begin bad++; $display("FAIL clr_after_count got=%0d exp=1", cnt_ov); end
    $display("clr final match=%b count=%0d", m_ov, cnt_ov);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; data_in = 1'b0; clr = 1'b0;
    test_reset();
    test_overlap_stream();
    test_en_gap();
    test_saturate();
    test_reset_mid();
    test_clr_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
